// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / UART front-end: data widths, ALU opcodes
// and the front-end FSM state encoding.
package alu_pkg;

  localparam int SIZEDATA = 8;
  localparam int SIZEOP   = 6;

  localparam logic [SIZEOP-1:0] OP_ADD = 6'b100000;
  localparam logic [SIZEOP-1:0] OP_SUB = 6'b100010;
  localparam logic [SIZEOP-1:0] OP_AND = 6'b100100;
  localparam logic [SIZEOP-1:0] OP_OR  = 6'b100101;
  localparam logic [SIZEOP-1:0] OP_XOR = 6'b100110;
  localparam logic [SIZEOP-1:0] OP_NOR = 6'b100111;
  localparam logic [SIZEOP-1:0] OP_SRA = 6'b000011;
  localparam logic [SIZEOP-1:0] OP_SRL = 6'b000010;

  localparam logic [2:0] S_A      = 3'd0;
  localparam logic [2:0] S_B      = 3'd1;
  localparam logic [2:0] S_OP     = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_TX     = 3'd4;
  localparam logic [2:0] S_TXWAIT = 3'd5;

  function automatic logic is_legal_op(input logic [SIZEOP-1:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_uart_if_if.sv
// Bundle of UART-side, ALU-side and transmit-handshake signals around the
// alu_uart_if front-end. master = the front-end, slave = UART/ALU side.
interface alu_uart_if_if #(
  parameter int SIZEDATA = alu_pkg::SIZEDATA,
  parameter int SIZEOP   = alu_pkg::SIZEOP
) ();

  logic [SIZEDATA-1:0] RX_DATA;
  logic                RX_DONE;
  logic                TX_DONE;
  logic [SIZEDATA-1:0] RESULT;
  logic [SIZEDATA-1:0] DATOA;
  logic [SIZEDATA-1:0] DATOB;
  logic [SIZEOP-1:0]   OPCODE;
  logic [SIZEDATA-1:0] TX_DATA;
  logic                TX_START;

  modport master (
    input  RX_DATA, RX_DONE, TX_DONE, RESULT,
    output DATOA, DATOB, OPCODE, TX_DATA, TX_START
  );

  modport slave (
    output RX_DATA, RX_DONE, TX_DONE, RESULT,
    input  DATOA, DATOB, OPCODE, TX_DATA, TX_START
  );

endinterface

// File: rtl/alu_uart_if.sv
// Frame collector (A, B, opcode) feeding the ALU and handing RESULT to the UART
// transmitter. Define ALU_UART_OPCHK_EN to drop frames with illegal opcodes.
module alu_uart_if #(
  parameter int SIZEDATA = alu_pkg::SIZEDATA,
  parameter int SIZEOP   = alu_pkg::SIZEOP
) (
  input  logic            CLK,
  input  logic            RESET_N,
  alu_uart_if_if.master   bus
);

  import alu_pkg::*;

  logic [2:0]          state_q, state_d;
  logic [SIZEDATA-1:0] datoa_q, datoa_d;
  logic [SIZEDATA-1:0] datob_q, datob_d;
  logic [SIZEOP-1:0]   opcode_q, opcode_d;
  logic [SIZEDATA-1:0] tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;

  always_comb begin
    state_d    = state_q;
    datoa_d    = datoa_q;
    datob_d    = datob_q;
    opcode_d   = opcode_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_A: begin
        if (bus.RX_DONE) begin
          datoa_d = bus.RX_DATA;
          state_d = S_B;
        end
      end
      S_B: begin
        if (bus.RX_DONE) begin
          datob_d = bus.RX_DATA;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (bus.RX_DONE) begin
`ifdef ALU_UART_OPCHK_EN
          if (is_legal_op(bus.RX_DATA[SIZEOP-1:0])) begin
            opcode_d = bus.RX_DATA[SIZEOP-1:0];
            state_d  = S_EXEC;
          end else begin
            state_d  = S_A;
          end
`else
          opcode_d = bus.RX_DATA[SIZEOP-1:0];
          state_d  = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        // TX_START is registered so it is high exactly while the FSM sits in S_TX.
        tx_data_d  = bus.RESULT;
        tx_start_d = 1'b1;
        state_d    = S_TX;
      end
      S_TX: begin
        state_d = S_TXWAIT;
      end
      S_TXWAIT: begin
        if (bus.TX_DONE) begin
          state_d = S_A;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_A;
      datoa_q    <= '0;
      datob_q    <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      datoa_q    <= datoa_d;
      datob_q    <= datob_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign bus.DATOA    = datoa_q;
  assign bus.DATOB    = datob_q;
  assign bus.OPCODE   = opcode_q;
  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_START = tx_start_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Randomised scoreboard bench for alu_uart_if; expectations follow
// ALU_UART_OPCHK_EN in the same way as the design build.
module tb_alu_uart_if;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   tx_seen;
  int   tx_expected;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] model_a, model_b, model_tx;
  logic [5:0] model_op;
  logic [5:0] legal_ops [8];

  alu_uart_if_if #(.SIZEDATA(8), .SIZEOP(6)) bus ();

  alu_uart_if #(.SIZEDATA(8), .SIZEOP(6)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic [7:0] r;
    case (op)
      6'b100000: r = a + b;
      6'b100010: r = a - b;
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      6'b000011: r = 8'($signed(a) >>> b);
      6'b000010: r = a >> b;
      default:   r = a ^ 8'h5A;
    endcase
    return r;
  endfunction

  function automatic logic op_accepted(input logic [5:0] op);
`ifdef ALU_UART_OPCHK_EN
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) if (legal_ops[i] == op) hit = 1'b1;
    return hit;
`else
    return (op == op) ? 1'b1 : 1'b0;
`endif
  endfunction

  always_comb bus.RESULT = alu_ref(bus.DATOA, bus.DATOB, bus.OPCODE);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every TX_START cycle consumes one expected frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.TX_START === 1'b1) begin
      tx_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_start actual=1 required=0 tx_data=%0h", bus.TX_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tx_data", 32'(bus.TX_DATA), 32'(e.res));
        chk("datoa",   32'(bus.DATOA),   32'(e.a));
        chk("datob",   32'(bus.DATOB),   32'(e.b));
        chk("opcode",  32'(bus.OPCODE),  32'(e.op));
        chk("tx_latency_cyc", 32'(cyc),  32'(e.cyc));
        $display("frame a=%0h b=%0h op=%0h tx_data=%0h exp=%0h", bus.DATOA, bus.DATOB,
                 bus.OPCODE, bus.TX_DATA, e.res);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int idle, output int drv_cyc);
    @(negedge clk);
    bus.RX_DATA = b;
    bus.RX_DONE = 1'b1;
    drv_cyc     = cyc;
    @(negedge clk);
    bus.RX_DONE = 1'b0;
    bus.RX_DATA = 8'($urandom);
    repeat (idle) @(negedge clk);
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_datoa"},   32'(bus.DATOA),   32'(model_a));
    chk({tag, "_datob"},   32'(bus.DATOB),   32'(model_b));
    chk({tag, "_opcode"},  32'(bus.OPCODE),  32'(model_op));
    chk({tag, "_tx_data"}, 32'(bus.TX_DATA), 32'(model_tx));
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] opbyte, input logic stray);
    int   dc;
    int   op_cyc;
    bit   seen;
    exp_t e;
    send_byte(a, $urandom_range(0, 2), dc);
    send_byte(b, $urandom_range(0, 2), dc);
    send_byte(opbyte, 0, op_cyc);
    model_a = a;
    model_b = b;
    if (op_accepted(opbyte[5:0])) begin
      model_op = opbyte[5:0];
      model_tx = alu_ref(a, b, opbyte[5:0]);
      e.a = a; e.b = b; e.op = opbyte[5:0]; e.res = model_tx;
      e.cyc = op_cyc + 2;
      exp_q.push_back(e);
      tx_expected++;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (bus.TX_START === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL tx_start_timeout actual=0 required=1");
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (stray) begin
        send_byte(8'h55, 1, dc);
        check_regs("stray");
      end
      @(negedge clk);
      bus.TX_DONE = 1'b1;
      @(negedge clk);
      bus.TX_DONE = 1'b0;
    end else begin
      repeat (6) @(negedge clk);
      check_regs("rejected");
    end
  endtask

  initial begin
    int dc;
    logic [7:0] opb;
    checks = 0; errors = 0; cyc = 0; tx_seen = 0; tx_expected = 0;
    legal_ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                  6'b100110, 6'b100111, 6'b000011, 6'b000010};
    bus.RX_DATA = '0; bus.RX_DONE = 1'b0; bus.TX_DONE = 1'b0;
    model_a = '0; model_b = '0; model_op = '0; model_tx = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_regs("async_reset");
    chk("async_reset_tx_start", 32'(bus.TX_START), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_frame(8'd7, 8'd2, 8'h20, 1'b0);
    run_frame(8'd7, 8'd2, 8'h22, 1'b0);
    run_frame(8'd7, 8'd2, 8'h24, 1'b0);
    run_frame(8'hF9, 8'd2, 8'h02, 1'b0);
    run_frame(8'hF9, 8'd2, 8'h03, 1'b0);
    run_frame(8'd7, 8'd2, 8'h20, 1'b1);
    run_frame(8'd7, 8'd2, 8'h27, 1'b0);

    // Abort a frame after two bytes; the next three bytes must form a new frame.
    send_byte(8'd7, 0, dc);
    send_byte(8'd2, 0, dc);
    rst_n = 1'b0;
    #1;
    model_a = '0; model_b = '0; model_op = '0; model_tx = '0;
    check_regs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'd12, 8'd5, 8'h22, 1'b0);

    run_frame(8'd7, 8'd2, 8'h3F, 1'b0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) != 0)
        opb = {2'($urandom), legal_ops[$urandom_range(0, 7)]};
      else
        opb = 8'($urandom);
      run_frame(8'($urandom), 8'($urandom_range(0, 9)), opb, 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("pending_frames", 32'(exp_q.size()), 32'd0);
    chk("tx_start_count", 32'(tx_seen), 32'(tx_expected));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
